// File: rtl/v_pkg.sv
// Shared types and widths for the vector store write buffer.
// Bank widths fall back to the data-memory defaults when not set by the build.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 10
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

package v_pkg;

  localparam int WB_ADDR_W = `DATAMEM_BITS;
  localparam int WB_DATA_W = `DATAMEM_WIDTH;
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [NUM_LANES-1:0]                lane_en;
    logic [NUM_LANES-1:0][WB_ADDR_W-1:0] addr;
    logic [NUM_LANES-1:0][WB_DATA_W-1:0] data;
    logic                                last;
  } v_wbuf_entry_t;

endpackage

// File: rtl/v_wbuf_fifo.sv
// Generic synchronous FIFO exposing the head entry and the entry behind it.
module v_wbuf_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  T                 wdata,
  output T                 head,
  output T                 head_next,
  output logic [OCC_W-1:0] occupancy
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/v_store_wbuf.sv
// Vector store write buffer: queues store beats and drains the head beat to
// four data-memory banks with independent per-lane commit.
module v_store_wbuf
  import v_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_lane_en,
  input  logic [ADDR_W-1:0]      in_addr0,
  input  logic [ADDR_W-1:0]      in_addr1,
  input  logic [ADDR_W-1:0]      in_addr2,
  input  logic [ADDR_W-1:0]      in_addr3,
  input  logic [DATA_W-1:0]      in_data0,
  input  logic [DATA_W-1:0]      in_data1,
  input  logic [DATA_W-1:0]      in_data2,
  input  logic [DATA_W-1:0]      in_data3,
  input  logic                   in_last,
  output logic [3:0]             bank_we,
  output logic [ADDR_W-1:0]      bank_addr0,
  output logic [ADDR_W-1:0]      bank_addr1,
  output logic [ADDR_W-1:0]      bank_addr2,
  output logic [ADDR_W-1:0]      bank_addr3,
  output logic [DATA_W-1:0]      bank_wdata0,
  output logic [DATA_W-1:0]      bank_wdata1,
  output logic [DATA_W-1:0]      bank_wdata2,
  output logic [DATA_W-1:0]      bank_wdata3,
  input  logic [3:0]             bank_ready,
  output logic                   store_done,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  v_wbuf_entry_t in_beat;
  v_wbuf_entry_t head;
  v_wbuf_entry_t head_next;
  logic [3:0]    pend;
  logic [3:0]    pend_nxt;
  logic [3:0]    commit;
  logic          nonempty;
  logic          push;
  logic          pop;

  assign in_beat = '{lane_en: in_lane_en,
                     addr:    {in_addr3, in_addr2, in_addr1, in_addr0},
                     data:    {in_data3, in_data2, in_data1, in_data0},
                     last:    in_last};

  assign nonempty = (occupancy != '0);
  assign in_ready = !rst && (occupancy != OCC_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign bank_we  = nonempty ? pend : 4'b0000;
  assign commit   = bank_we & bank_ready;
  // A beat leaves once every lane still pending commits this cycle.
  assign pop      = nonempty && ((pend & ~bank_ready) == 4'b0000);

  v_wbuf_fifo #(
    .T     (v_wbuf_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (in_beat),
    .head      (head),
    .head_next (head_next),
    .occupancy (occupancy)
  );

  // The next head is either already queued behind this one or arriving now.
  always_comb begin
    pend_nxt = pend & ~commit;
    if (pop) begin
      if (occupancy > OCC_W'(1)) pend_nxt = head_next.lane_en;
      else if (push)             pend_nxt = in_beat.lane_en;
      else                       pend_nxt = 4'b0000;
    end else if (!nonempty && push) begin
      pend_nxt = in_beat.lane_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= 4'b0000;
      store_done <= 1'b0;
    end else begin
      pend       <= pend_nxt;
      store_done <= pop && head.last;
    end
  end

  assign bank_addr0  = nonempty ? head.addr[0] : '0;
  assign bank_addr1  = nonempty ? head.addr[1] : '0;
  assign bank_addr2  = nonempty ? head.addr[2] : '0;
  assign bank_addr3  = nonempty ? head.addr[3] : '0;
  assign bank_wdata0 = nonempty ? head.data[0] : '0;
  assign bank_wdata1 = nonempty ? head.data[1] : '0;
  assign bank_wdata2 = nonempty ? head.data[2] : '0;
  assign bank_wdata3 = nonempty ? head.data[3] : '0;

endmodule

// File: tb/tb_v_store_wbuf.sv
// Directed bench for v_store_wbuf with a queue-based reference model
// checked every cycle, plus literal checks for each scenario.
module tb_v_store_wbuf;
  import v_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = WB_ADDR_W;
  localparam int DW    = WB_DATA_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [3:0]           in_lane_en = '0;
  logic [3:0][AW-1:0]   in_addr = '0;
  logic [3:0][DW-1:0]   in_data = '0;
  logic                 in_last = 1'b0;
  logic [3:0]           bank_we;
  logic [3:0][AW-1:0]   b_addr;
  logic [3:0][DW-1:0]   b_wdata;
  logic [3:0]           bank_ready = '0;
  logic                 store_done;
  logic [3:0]           occupancy;

  v_store_wbuf #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_lane_en  (in_lane_en),
    .in_addr0    (in_addr[0]),
    .in_addr1    (in_addr[1]),
    .in_addr2    (in_addr[2]),
    .in_addr3    (in_addr[3]),
    .in_data0    (in_data[0]),
    .in_data1    (in_data[1]),
    .in_data2    (in_data[2]),
    .in_data3    (in_data[3]),
    .in_last     (in_last),
    .bank_we     (bank_we),
    .bank_addr0  (b_addr[0]),
    .bank_addr1  (b_addr[1]),
    .bank_addr2  (b_addr[2]),
    .bank_addr3  (b_addr[3]),
    .bank_wdata0 (b_wdata[0]),
    .bank_wdata1 (b_wdata[1]),
    .bank_wdata2 (b_wdata[2]),
    .bank_wdata3 (b_wdata[3]),
    .bank_ready  (bank_ready),
    .store_done  (store_done),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]         en;
    logic [3:0][AW-1:0] a;
    logic [3:0][DW-1:0] d;
    logic               last;
  } beat_t;

  beat_t      mq[$];
  logic [3:0] m_mask = '0;
  logic       m_done = 1'b0;
  bit         chk_en = 1'b0;
  int         vectors = 0;
  int         errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of beats, lanes already written for the head.
  initial begin
    logic [3:0] rem;
    logic       acc;
    beat_t      b;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_mask = '0;
        m_done = 1'b0;
      end else begin
        acc    = in_valid && (mq.size() < DEPTH);
        m_done = 1'b0;
        if (mq.size() > 0) begin
          rem = mq[0].en & ~m_mask;
          if ((rem & ~bank_ready) == 4'b0000) begin
            m_done = mq[0].last;
            void'(mq.pop_front());
            m_mask = '0;
          end else begin
            m_mask = m_mask | (rem & bank_ready);
          end
        end
        if (acc) begin
          b.en = in_lane_en; b.a = in_addr; b.d = in_data; b.last = in_last;
          mq.push_back(b);
        end
      end
    end
  end

  initial begin
    logic [3:0] e_we;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_we = (mq.size() > 0) ? (mq[0].en & ~m_mask) : 4'b0000;
        chk("bank_we", bank_we, e_we);
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("bank_addr%0d", i), b_addr[i], (mq.size() > 0) ? mq[0].a[i] : '0);
          chk($sformatf("bank_wdata%0d", i), b_wdata[i], (mq.size() > 0) ? mq[0].d[i] : '0);
        end
        chk("store_done", store_done, m_done);
        chk("occupancy", occupancy, mq.size());
        chk("in_ready", in_ready, !rst && (mq.size() < DEPTH));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_beat(input logic [3:0] en, input int abase, input int dbase, input logic last);
    in_lane_en = en;
    for (int i = 0; i < 4; i++) begin
      in_addr[i] = AW'(abase + i);
      in_data[i] = DW'(dbase + i);
    end
    in_last = last;
  endtask

  task automatic push_one(input logic [3:0] en, input int abase, input int dbase, input logic last);
    set_beat(en, abase, dbase, last);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int done_cnt;
    int we_cnt;
    logic [3:0] seen_odd;

    // Reset
    tick();
    chk_en = 1'b1;
    tick();
    at_neg();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_bank_we", bank_we, 0);
    chk("rst_store_done", store_done, 0);
    tick();
    rst = 1'b0;
    at_neg();
    chk("post_rst_in_ready", in_ready, 1);

    // Contiguous single beat
    bank_ready = 4'hF;
    push_one(4'hF, 'h40, 'hA0, 1'b1);
    at_neg();
    chk("s1_we", bank_we, 4'hF);
    chk("s1_addr2", b_addr[2], 'h42);
    chk("s1_wdata3", b_wdata[3], 'hA3);
    chk("s1_done_early", store_done, 0);
    chk("s1_occ", occupancy, 1);
    tick(); at_neg();
    chk("s1_we_after", bank_we, 0);
    chk("s1_done", store_done, 1);
    chk("s1_occ_after", occupancy, 0);
    tick(); at_neg();
    chk("s1_done_single", store_done, 0);

    // Bank stall on lane 2
    bank_ready = 4'b1011;
    push_one(4'hF, 'h40, 'hA0, 1'b1);
    at_neg();
    chk("s2_we_first", bank_we, 4'hF);
    for (int c = 0; c < 3; c++) begin
      tick(); at_neg();
      chk("s2_we_stall", bank_we, 4'b0100);
      chk("s2_addr2_stall", b_addr[2], 'h42);
      chk("s2_done_stall", store_done, 0);
    end
    bank_ready = 4'hF;
    tick(); at_neg();
    chk("s2_we_done", bank_we, 0);
    chk("s2_done", store_done, 1);
    chk("s2_occ", occupancy, 0);

    // Strided: lanes 0 and 2 only, four beats, one instruction
    done_cnt = 0; we_cnt = 0; seen_odd = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        set_beat(4'b0101, 'h100 + 16 * k, 'hB00 + 16 * k, k == 3);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick(); at_neg();
      seen_odd = seen_odd | (bank_we & 4'b1010);
      if (store_done) done_cnt++;
      if (bank_we == 4'b0101) begin
        chk("s3_addr0_order", b_addr[0], 'h100 + 16 * we_cnt);
        we_cnt++;
      end
    end
    chk("s3_odd_lanes", seen_odd, 0);
    chk("s3_pops", we_cnt, 4);
    chk("s3_done_cnt", done_cnt, 1);

    // Full: stalled banks, eight beats, ninth refused, drain in order across wrap
    bank_ready = 4'h0;
    for (int k = 0; k < 8; k++) begin
      set_beat(4'hF, 'h200 + 8 * k, 'hC00 + 8 * k, k == 7);
      in_valid = 1'b1;
      tick();
    end
    set_beat(4'hF, 'h3F0, 'hDEAD, 1'b1);
    at_neg();
    chk("s4_in_ready_full", in_ready, 0);
    chk("s4_occ_full", occupancy, 8);
    tick(); at_neg();
    chk("s4_occ_hold", occupancy, 8);
    in_valid = 1'b0;
    bank_ready = 4'hF;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      chk("s4_we_drain", bank_we, 4'hF);
      chk("s4_addr3_order", b_addr[3], 'h200 + 8 * k + 3);
      chk("s4_wdata1_order", b_wdata[1], 'hC00 + 8 * k + 1);
      if (store_done) done_cnt++;
      tick(); at_neg();
    end
    chk("s4_done", store_done, 1);
    chk("s4_done_cnt", done_cnt, 0);
    chk("s4_occ_empty", occupancy, 0);
    chk("s4_we_empty", bank_we, 0);

    // Empty-lane last beat
    push_one(4'h0, 'h50, 'h55, 1'b1);
    at_neg();
    chk("s5_we", bank_we, 0);
    chk("s5_done_early", store_done, 0);
    chk("s5_occ", occupancy, 1);
    tick(); at_neg();
    chk("s5_done", store_done, 1);
    chk("s5_occ_after", occupancy, 0);
    tick(); at_neg();
    chk("s5_done_single", store_done, 0);

    // Reset mid-operation
    bank_ready = 4'h0;
    for (int k = 0; k < 3; k++) push_one(4'hF, 'h60 + 4 * k, 'hE0 + 4 * k, 1'b1);
    at_neg();
    chk("s6_occ_queued", occupancy, 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_neg();
    chk("s6_occ", occupancy, 0);
    chk("s6_we", bank_we, 0);
    chk("s6_addr0", b_addr[0], 0);
    chk("s6_wdata2", b_wdata[2], 0);
    chk("s6_done", store_done, 0);
    chk("s6_in_ready", in_ready, 1);
    bank_ready = 4'hF;
    tick(); at_neg();
    chk("s6_no_done", store_done, 0);
    push_one(4'hF, 'h40, 'hA0, 1'b1);
    at_neg();
    chk("s6_we_again", bank_we, 4'hF);
    chk("s6_addr1_again", b_addr[1], 'h41);
    tick(); at_neg();
    chk("s6_done_again", store_done, 1);
    chk("s6_occ_again", occupancy, 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
